det_stream_arbiter: RTL

Round-robin controller that shares one bit-serial Mealy pattern detector among `NREQ` byte-wide requesters. It accepts one byte at a time, serializes it MSB-first into the detector, counts detections over that byte, and reports the count with the winning requester's ID. It sits between the parallel producers and the serial detector core, and is the only block allowed to drive the detector input.

---
 rtl/det_arb_pkg.sv | 23 ++
 rtl/seq_det_core.sv | 43 ++++
 rtl/det_stream_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/det_arb_pkg.sv
// Shared types and helpers for the round-robin serial pattern-detector arbiter.
// Latency: none (package only).
// Backpressure: n/a.
package det_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1010;

  // Ceiling log2 for parameter sizing; callers never pass values below 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial Mealy pattern detector with clearable history.
// Latency: det is combinational on x in the same cycle; history updates on the clock.
// Backpressure: none; en qualifies each bit, clr restarts the history.
// Ports: clk, rst (sync, active-low), clr (restart history), en (bit valid),
//        x (serial bit, oldest-first), det (pattern completes on this bit).
module seq_det_core
  import det_arb_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic det
);

  localparam int FW = clog2(PAT_LEN);

  logic [PAT_LEN-2:0] hist;
  logic [PAT_LEN-1:0] win;
  logic [FW-1:0]      fill;
  logic               full;

  assign win  = {hist, x};
  // Only complete windows may match; otherwise the zero-filled history could
  // fake a hit for patterns with leading zeros.
  assign full = (fill == FW'(PAT_LEN - 1));
  assign det  = en && full && (win == PATTERN);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= win[PAT_LEN-2:0];
      if (!full) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/det_stream_arbiter.sv
// Round-robin arbiter feeding one word at a time MSB-first into a shared serial detector.
// Latency: grant at T, bits on x at T+1..T+DW, done with match count at T+DW+1.
// Backpressure: requesters hold req until a gnt pulse; one word accepted per DW+2 cycles.
// Ports: clk, rst (sync, active-low), req/data (per-requester words), gnt (one-hot capture
//        pulse), busy, x/det (detector monitor), done/done_id/match_cnt (result).
module det_stream_arbiter
  import det_arb_pkg::*;
#(
  parameter int                 NREQ    = 2,
  parameter int                 DW      = 8,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  localparam int                CW      = clog2(DW + 1),
  localparam int                IW      = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               x,
  output logic               det,
  output logic               done,
  output logic [IW-1:0]      done_id,
  output logic [CW-1:0]      match_cnt
);

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   cur_id;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic            any;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   bitcnt;
  logic [CW-1:0]   cnt;
  logic            shifting;

  // Rotating priority: scan from the requester after the last winner.
  // Gated by rst so nothing is granted while reset is being applied.
  always_comb begin
    any  = 1'b0;
    sel  = '0;
    cand = '0;
    gnt  = '0;
    if (rst && state == IDLE) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IW'((int'(last) + k) % NREQ);
        if (!any && req[cand]) begin
          any       = 1'b1;
          sel       = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  assign shifting = (state == SHIFT);
  assign busy     = (state != IDLE);
  assign done     = (state == REPORT);
  assign x        = shifting ? shreg[DW-1] : 1'b0;

  seq_det_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk (clk),
    .rst (rst),
    .clr (any),
    .en  (shifting),
    .x   (x),
    .det (det)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      cur_id    <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      match_cnt <= '0;
      done_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            shreg  <= data[int'(sel)*DW +: DW];
            cur_id <= sel;
            last   <= sel;
            bitcnt <= CW'(DW - 1);
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg[DW-2:0], 1'b0};
          if (det) cnt <= cnt + 1'b1;
          if (bitcnt == '0) begin
            // Fold in the final bit's detection so the result is ready in REPORT.
            match_cnt <= cnt + CW'(det);
            done_id   <= cur_id;
            state     <= REPORT;
          end else begin
            bitcnt <= bitcnt - 1'b1;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
